// File: rtl/parity_pkg.sv
// Shared types and constants for the parity scheduler and its parity unit.
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } sched_state_t;

   localparam logic MODE_EVEN = 1'b0;
   localparam logic MODE_ODD  = 1'b1;

endpackage

// File: rtl/parity_unit.sv
// Combinational parity generator: even mode returns XOR of the word, odd mode its inverse.
module parity_unit #(
   parameter int DW = 4
) (
   input  logic [DW-1:0] data_in,
   input  logic          mode,
   output logic          parity_out
);
   import parity_pkg::*;

   always_comb begin
      parity_out = (mode == MODE_ODD) ? ~(^data_in) : (^data_in);
   end

endmodule

// File: rtl/parity_sched.sv
// Round-robin scheduler sharing one parity unit among NREQ requesters, valid/ready result port.
// Optional macro PARITY_SCHED_CHECK_EN adds exp_par input and out_err output.
module parity_sched
   import parity_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int DW   = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] data,
   input  logic [NREQ-1:0]    mode,
`ifdef PARITY_SCHED_CHECK_EN
   input  logic [NREQ-1:0]    exp_par,
   output logic               out_err,
`endif
   output logic [NREQ-1:0]    req_ack,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_parity,
   output logic [IDW-1:0]     out_id,
   output logic               busy
);

   sched_state_t    state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]  cap_id_q, cap_id_d;
   logic [DW-1:0]   cap_data_q, cap_data_d;
   logic            cap_mode_q, cap_mode_d;
   logic [NREQ-1:0] req_ack_q, req_ack_d;
   logic            out_valid_q, out_valid_d;
   logic            out_parity_q, out_parity_d;
   logic [IDW-1:0]  out_id_q, out_id_d;
   logic            busy_q, busy_d;
`ifdef PARITY_SCHED_CHECK_EN
   logic            cap_exp_q, cap_exp_d;
   logic            out_err_q, out_err_d;
`endif

   logic [NREQ-1:0] req_rot;
   logic [IDW:0]    grant_off;
   logic [IDW:0]    idx_sum;
   logic [IDW-1:0]  grant_idx;
   logic            grant_found;
   logic            unit_parity;

   parity_unit #(.DW(DW)) u_parity (
      .data_in    (cap_data_q),
      .mode       (cap_mode_q),
      .parity_out (unit_parity)
   );

   // Rotate so rr_ptr lands at bit 0; the lowest set bit of the rotated vector is the winner.
   always_comb begin
      req_rot     = NREQ'({req, req} >> rr_ptr_q);
      grant_found = |req;
      grant_off   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            grant_off = (IDW+1)'(k);
         end
      end
      idx_sum   = {1'b0, rr_ptr_q} + grant_off;
      grant_idx = (idx_sum >= (IDW+1)'(NREQ)) ? IDW'(idx_sum - (IDW+1)'(NREQ))
                                              : idx_sum[IDW-1:0];
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      cap_id_d     = cap_id_q;
      cap_data_d   = cap_data_q;
      cap_mode_d   = cap_mode_q;
      req_ack_d    = '0;
      out_valid_d  = out_valid_q;
      out_parity_d = out_parity_q;
      out_id_d     = out_id_q;
`ifdef PARITY_SCHED_CHECK_EN
      cap_exp_d    = cap_exp_q;
      out_err_d    = out_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               cap_id_d = grant_idx;
               for (int i = 0; i < NREQ; i++) begin
                  if (grant_idx == IDW'(i)) begin
                     req_ack_d[i] = 1'b1;
                     cap_data_d   = data[i*DW +: DW];
                     cap_mode_d   = mode[i];
`ifdef PARITY_SCHED_CHECK_EN
                     cap_exp_d    = exp_par[i];
`endif
                  end
               end
               state_d = CALC;
            end
         end
         CALC: begin
            out_parity_d = unit_parity;
            out_id_d     = cap_id_q;
            out_valid_d  = 1'b1;
`ifdef PARITY_SCHED_CHECK_EN
            out_err_d    = unit_parity ^ cap_exp_q;
`endif
            rr_ptr_d     = (cap_id_q == IDW'(NREQ - 1)) ? '0 : cap_id_q + 1'b1;
            state_d      = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         cap_id_q     <= '0;
         cap_data_q   <= '0;
         cap_mode_q   <= MODE_EVEN;
         req_ack_q    <= '0;
         out_valid_q  <= 1'b0;
         out_parity_q <= 1'b0;
         out_id_q     <= '0;
         busy_q       <= 1'b0;
`ifdef PARITY_SCHED_CHECK_EN
         cap_exp_q    <= 1'b0;
         out_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         cap_id_q     <= cap_id_d;
         cap_data_q   <= cap_data_d;
         cap_mode_q   <= cap_mode_d;
         req_ack_q    <= req_ack_d;
         out_valid_q  <= out_valid_d;
         out_parity_q <= out_parity_d;
         out_id_q     <= out_id_d;
         busy_q       <= busy_d;
`ifdef PARITY_SCHED_CHECK_EN
         cap_exp_q    <= cap_exp_d;
         out_err_q    <= out_err_d;
`endif
      end
   end

   assign req_ack    = req_ack_q;
   assign out_valid  = out_valid_q;
   assign out_parity = out_parity_q;
   assign out_id     = out_id_q;
   assign busy       = busy_q;
`ifdef PARITY_SCHED_CHECK_EN
   assign out_err    = out_err_q;
`endif

endmodule

// File: tb/tb_parity_sched.sv
// Self-checking bench for parity_sched with a queue-free round-robin reference model.
module tb_parity_sched;

   localparam int NREQ = 4;
   localparam int DW   = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] data;
   logic [3:0]  mode;
   logic [3:0]  req_ack;
   logic        out_valid;
   logic        out_ready;
   logic        out_parity;
   logic [1:0]  out_id;
   logic        busy;
`ifdef PARITY_SCHED_CHECK_EN
   logic [3:0]  exp_par;
   logic        out_err;
`endif

   int errors    = 0;
   int checks    = 0;
   int model_ptr = 0;

   always #5 clk = ~clk;

   parity_sched #(.NREQ(NREQ), .DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .data       (data),
      .mode       (mode),
`ifdef PARITY_SCHED_CHECK_EN
      .exp_par    (exp_par),
      .out_err    (out_err),
`endif
      .req_ack    (req_ack),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_parity (out_parity),
      .out_id     (out_id),
      .busy       (busy)
   );

   // Reference: first requesting index at or after ptr, modulo NREQ.
   function automatic int rr_pick(input logic [3:0] r, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic ref_par(input logic [3:0] d, input logic m);
      return 1'($countones(d) % 2) ^ m;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; req = '0; out_ready = 1'b1;
      tick(); tick();
      rst_n = 1'b1; model_ptr = 0;
   endtask

   // Raise r, wait (bounded) for an ack, then drop the acked bit.
   task automatic serve(input logic [3:0] r, output logic [3:0] ack, output int lat);
      req = r; lat = 0; ack = '0;
      while (lat < 20) begin
         tick(); lat++;
         if (req_ack != 0) break;
      end
      ack = req_ack;
      req = r & ~req_ack;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 4'($urandom); data = 16'($urandom); mode = 4'($urandom); out_ready = 1'b1;
`ifdef PARITY_SCHED_CHECK_EN
      exp_par = 4'($urandom);
`endif
      tick(); tick();
      checks++;
      if ({req_ack, out_valid, out_parity, out_id} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got ack=%b valid=%b par=%b id=%0d, want all 0", req_ack, out_valid, out_parity, out_id);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b want 0", busy);
      end
`ifdef PARITY_SCHED_CHECK_EN
      checks++;
      if (out_err !== 1'b0) begin
         errors++; $display("FAIL reset_err: got %b want 0", out_err);
      end
`endif
      rst_n = 1'b1; req = '0; model_ptr = 0;
      tick();
   endtask

   task automatic test_single();
      logic [3:0] ack; int lat;
      data = 16'($urandom); data[3:0] = 4'b1011; mode = 4'($urandom); mode[0] = 1'b0; out_ready = 1'b1;
      serve(4'b0001, ack, lat);
      checks++;
      if (ack !== 4'b0001 || lat != 1) begin
         errors++; $display("FAIL single_ack: got ack=%b lat=%0d, want 0001 lat=1", ack, lat);
      end
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL single_calc: got valid=%b busy=%b, want 0 1", out_valid, busy);
      end
      tick();
      checks++;
      if (req_ack !== 4'b0000) begin
         errors++; $display("FAIL single_ack_pulse: got %b want 0000", req_ack);
      end
      checks++;
      if (out_valid !== 1'b1 || out_parity !== 1'b1 || out_id !== 2'd0) begin
         errors++; $display("FAIL single_result: got valid=%b par=%b id=%0d, want 1 1 0", out_valid, out_parity, out_id);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_accept: got valid=%b busy=%b, want 0 0", out_valid, busy);
      end
      model_ptr = 1;
   endtask

   task automatic test_odd();
      logic [3:0] ack; int lat;
      logic [3:0] words [2];
      logic       want  [2];
      words[0] = 4'b1100; want[0] = 1'b1;
      words[1] = 4'b1110; want[1] = 1'b0;
      for (int n = 0; n < 2; n++) begin
         data[11:8] = words[n]; mode[2] = 1'b1; out_ready = 1'b1;
         serve(4'b0100, ack, lat);
         checks++;
         if (ack !== 4'b0100) begin
            errors++; $display("FAIL odd_ack%0d: got %b want 0100", n, ack);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_id !== 2'd2 || out_parity !== want[n]) begin
            errors++; $display("FAIL odd_result%0d: got valid=%b id=%0d par=%b, want 1 2 %b", n, out_valid, out_id, out_parity, want[n]);
         end
         tick();
      end
      model_ptr = 3;
   endtask

   task automatic test_round_robin();
      logic [3:0] ack; int lat; int exp_id; logic [3:0] served;
      apply_reset();
      data = 16'($urandom); mode = 4'($urandom); served = '0;
      for (int n = 0; n < 5; n++) begin
         exp_id = rr_pick(4'b1111, model_ptr);
         serve(4'b1111, ack, lat);
         tick();
         checks++;
         if (out_id !== 2'(exp_id) || ack !== 4'(1 << exp_id) || out_valid !== 1'b1 ||
             out_parity !== ref_par(data[exp_id*4 +: 4], mode[exp_id])) begin
            errors++;
            $display("FAIL rr_order%0d: got id=%0d ack=%b par=%b, want id=%0d par=%b", n, out_id, ack, out_parity,
                     exp_id, ref_par(data[exp_id*4 +: 4], mode[exp_id]));
         end
         if (n < 4) begin
            checks++;
            if (served[out_id] !== 1'b0) begin
               errors++; $display("FAIL rr_fair%0d: id %0d served twice, served=%b", n, out_id, served);
            end
            served[out_id] = 1'b1;
         end
         req = 4'b1111;
         model_ptr = (exp_id + 1) % NREQ;
      end
      req = '0;
      tick();
   endtask

   task automatic test_backpressure();
      logic [3:0] ack; int lat; logic want_par;
      req = '0; out_ready = 1'b0; data = 16'($urandom); mode = 4'($urandom);
      want_par = ref_par(data[3:0], mode[0]);
      serve(4'b0001, ack, lat);
      checks++;
      if (ack !== 4'b0001) begin
         errors++; $display("FAIL bp_ack0: got %b want 0001", ack);
      end
      req = 4'b0010;
      tick();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_id !== 2'd0 || out_parity !== want_par || req_ack !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold%0d: got valid=%b id=%0d par=%b ack=%b busy=%b, want 1 0 %b 0000 1",
                     c, out_valid, out_id, out_parity, req_ack, busy, want_par);
         end
         if (c < 4) tick();
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || req_ack !== 4'b0000) begin
         errors++; $display("FAIL bp_accept: got valid=%b ack=%b, want 0 0000", out_valid, req_ack);
      end
      tick();
      checks++;
      if (req_ack !== 4'b0010) begin
         errors++; $display("FAIL bp_grant1: got %b want 0010", req_ack);
      end
      req = '0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd1) begin
         errors++; $display("FAIL bp_result1: got valid=%b id=%0d, want 1 1", out_valid, out_id);
      end
      tick();
      model_ptr = 2;
   endtask

   task automatic test_reset_mid();
      logic [3:0] ack; int lat; int quiet_bad;
      out_ready = 1'b1; req = '0;
      serve(4'b0001, ack, lat);
      checks++;
      if (ack !== 4'b0001) begin
         errors++; $display("FAIL rmid_ack: got %b want 0001", ack);
      end
      rst_n = 1'b0; req = '0;
      tick();
      checks++;
      if ({req_ack, out_valid, out_parity, out_id, busy} !== 9'h000) begin
         errors++;
         $display("FAIL rmid_clear: got ack=%b valid=%b par=%b id=%0d busy=%b, want all 0", req_ack, out_valid, out_parity, out_id, busy);
      end
      rst_n = 1'b1; model_ptr = 0; quiet_bad = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (out_valid !== 1'b0 || req_ack !== 4'b0000) quiet_bad++;
      end
      checks++;
      if (quiet_bad != 0) begin
         errors++; $display("FAIL rmid_quiet: got %0d cycles with activity, want 0", quiet_bad);
      end
      serve(4'b1000, ack, lat);
      checks++;
      if (ack !== 4'b1000) begin
         errors++; $display("FAIL rmid_grant3: got %b want 1000", ack);
      end
      tick();
      checks++;
      if (out_id !== 2'd3 || out_valid !== 1'b1) begin
         errors++; $display("FAIL rmid_id3: got id=%0d valid=%b, want 3 1", out_id, out_valid);
      end
      tick();
      serve(4'b1111, ack, lat);
      req = '0;
      checks++;
      if (ack !== 4'b0001) begin
         errors++; $display("FAIL rmid_wrap: got %b want 0001", ack);
      end
      tick(); tick();
      model_ptr = 1;
   endtask

`ifdef PARITY_SCHED_CHECK_EN
   task automatic test_check();
      logic [3:0] ack; int lat;
      for (int n = 0; n < 2; n++) begin
         data[3:0] = 4'b0001; mode[0] = 1'b0; exp_par[0] = 1'(n); out_ready = 1'b1;
         serve(4'b0001, ack, lat);
         tick();
         checks++;
         if (out_parity !== 1'b1 || out_err !== 1'(1 - n) || out_id !== 2'd0) begin
            errors++; $display("FAIL check_err%0d: got par=%b err=%b id=%0d, want 1 %0d 0", n, out_parity, out_err, out_id, 1 - n);
         end
         tick();
      end
      model_ptr = 1;
   endtask
`endif

   task automatic test_random();
      logic [3:0] ack, r; int lat, sel, waited; logic want_par, rdy, accepted;
`ifdef PARITY_SCHED_CHECK_EN
      logic want_err;
`endif
      for (int t = 0; t < 40; t++) begin
         r = 4'($urandom_range(1, 15)); data = 16'($urandom); mode = 4'($urandom);
         sel = rr_pick(r, model_ptr);
         want_par = ref_par(data[sel*4 +: 4], mode[sel]);
`ifdef PARITY_SCHED_CHECK_EN
         exp_par = 4'($urandom); want_err = want_par ^ exp_par[sel];
`endif
         serve(r, ack, lat);
         req = '0;
         checks++;
         if (ack !== 4'(1 << sel)) begin
            errors++; $display("FAIL rand_ack%0d: got %b want %b (req=%b ptr=%0d)", t, ack, 4'(1 << sel), r, model_ptr);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_id !== 2'(sel) || out_parity !== want_par) begin
            errors++; $display("FAIL rand_result%0d: got valid=%b id=%0d par=%b, want 1 %0d %b", t, out_valid, out_id, out_parity, sel, want_par);
         end
`ifdef PARITY_SCHED_CHECK_EN
         checks++;
         if (out_err !== want_err) begin
            errors++; $display("FAIL rand_err%0d: got %b want %b", t, out_err, want_err);
         end
`endif
         $display("txn %0d req=%b id=%0d par=%b", t, r, out_id, out_parity);
         waited = 0; accepted = 1'b0;
         while (!accepted && waited < 20) begin
            out_ready = (waited >= 10) ? 1'b1 : 1'($urandom % 2);
            rdy = out_ready;
            tick(); waited++;
            checks++;
            if (rdy) begin
               accepted = 1'b1;
               if (out_valid !== 1'b0 || busy !== 1'b0) begin
                  errors++; $display("FAIL rand_accept%0d: got valid=%b busy=%b, want 0 0", t, out_valid, busy);
               end
            end else if (out_valid !== 1'b1 || out_id !== 2'(sel) || out_parity !== want_par || busy !== 1'b1 || req_ack !== 4'b0000) begin
               errors++;
               $display("FAIL rand_hold%0d: got valid=%b id=%0d par=%b busy=%b ack=%b", t, out_valid, out_id, out_parity, busy, req_ack);
            end
         end
         model_ptr = (sel + 1) % NREQ;
      end
      out_ready = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req = '0; data = '0; mode = '0; out_ready = 1'b1;
`ifdef PARITY_SCHED_CHECK_EN
      exp_par = '0;
`endif
      tick();
      test_reset();
      test_single();
      test_odd();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
`ifdef PARITY_SCHED_CHECK_EN
      test_check();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
